// File: rtl/data_memory_responder.sv
// data_memory_responder
//   Off-chip data memory model serving line-sized read/write requests from the MEM
//   stage's data-cache side. A request is accepted in idle, served after a fixed
//   latency, and completion is flagged with a single-cycle ack. Read data is
//   presented with the ack and then held until the next read ack or reset.
//
// Ports
//   clk_i     clock, rising edge
//   rst_i     asynchronous active-low reset
//   enable_i  request valid, sampled only while idle
//   write_i   1 = write line, 0 = read line (latched at accept)
//   addr_i    byte address; only the line-index field is used
//   data_i    write line (latched at accept)
//   ack_o     one-cycle completion pulse
//   data_o    read line, valid with ack_o on a read and held afterwards
module data_memory_responder #(
  parameter int unsigned LATENCY = 10,
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned DEPTH   = 512
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [31:0]       addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o
);

  localparam int unsigned OffW = $clog2(LINE_W / 8);
  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(LATENCY);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StAck  = 2'd2;

  logic [LINE_W-1:0] mem [DEPTH];

  logic [1:0]        stateQ, stateD;
  logic [CntW-1:0]   cntQ, cntD;
  logic              reqWriteQ, reqWriteD;
  logic [IdxW-1:0]   reqIdxQ, reqIdxD;
  logic [LINE_W-1:0] reqDataQ, reqDataD;
  logic              ackQ, ackD;
  logic [LINE_W-1:0] dataQ, dataD;
  logic              lastBusy;
  logic              unusedAddr;

  // Byte offset and bits above the index field alias onto the same line.
  assign unusedAddr = ^{addr_i[31:OffW+IdxW], addr_i[OffW-1:0]};

  // The counter starts at 0 on the accept edge, so the edge that sees LATENCY-1
  // is LATENCY edges after accept: that edge raises ack and commits the access.
  assign lastBusy = (stateQ == StBusy) && (cntQ == CntW'(LATENCY - 1));

  always_comb begin
    stateD    = stateQ;
    cntD      = cntQ;
    reqWriteD = reqWriteQ;
    reqIdxD   = reqIdxQ;
    reqDataD  = reqDataQ;
    ackD      = 1'b0;
    dataD     = dataQ;
    unique case (stateQ)
      StIdle: begin
        if (enable_i) begin
          stateD    = StBusy;
          cntD      = '0;
          reqWriteD = write_i;
          reqIdxD   = addr_i[OffW+IdxW-1:OffW];
          reqDataD  = data_i;
        end
      end
      StBusy: begin
        if (lastBusy) begin
          stateD = StAck;
          ackD   = 1'b1;
          if (!reqWriteQ) begin
            dataD = mem[reqIdxQ];
          end
        end else begin
          cntD = cntQ + CntW'(1);
        end
      end
      StAck: begin
        stateD = StIdle;
      end
      default: begin
        stateD = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stateQ    <= StIdle;
      cntQ      <= '0;
      reqWriteQ <= 1'b0;
      reqIdxQ   <= '0;
      reqDataQ  <= '0;
      ackQ      <= 1'b0;
      dataQ     <= '0;
    end else begin
      stateQ    <= stateD;
      cntQ      <= cntD;
      reqWriteQ <= reqWriteD;
      reqIdxQ   <= reqIdxD;
      reqDataQ  <= reqDataD;
      ackQ      <= ackD;
      dataQ     <= dataD;
    end
  end

  // Array is not reset; reset forces idle, which also cancels a pending write.
  always_ff @(posedge clk_i) begin
    if (lastBusy && reqWriteQ) begin
      mem[reqIdxQ] <= reqDataQ;
    end
  end

  assign ack_o  = ackQ;
  assign data_o = dataQ;

endmodule

// File: tb/tb_data_memory_responder.sv
module tb_data_memory_responder;

  localparam int unsigned LAT = 10;

  logic         clk_i;
  logic         rst_i;
  logic         enable_i;
  logic         write_i;
  logic [31:0]  addr_i;
  logic [255:0] data_i;
  logic         ack_o;
  logic [255:0] data_o;

  int checks;
  int errors;

  data_memory_responder #(
    .LATENCY(LAT),
    .LINE_W (256),
    .DEPTH  (512)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .enable_i(enable_i),
    .write_i (write_i),
    .addr_i  (addr_i),
    .data_i  (data_i),
    .ack_o   (ack_o),
    .data_o  (data_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, check ack timing edge by edge, leave the bench #1 after the
  // ack edge. Optionally disturb the inputs at edge chgAt after accept.
  task automatic doReq(input string tag, input logic w, input logic [31:0] a,
                       input logic [255:0] d, input int chgAt);
    @(negedge clk_i);
    enable_i = 1'b1;
    write_i  = w;
    addr_i   = a;
    data_i   = d;
    @(posedge clk_i); #1;
    enable_i = 1'b0;
    for (int k = 1; k <= int'(LAT); k++) begin
      @(posedge clk_i); #1;
      check({tag, "_ack"}, {255'd0, ack_o}, {255'd0, (k == int'(LAT))});
      if (k == chgAt) begin
        addr_i  = 32'h0000_0040;
        write_i = ~w;
        data_i  = {8{32'hFFFF_0000}};
      end
    end
  endtask

  task automatic finishReq(input string tag);
    @(posedge clk_i); #1;
    check({tag, "_ackfall"}, {255'd0, ack_o}, 256'd0);
  endtask

  logic [255:0] pA5;
  int pulses;

  initial begin
    checks   = 0;
    errors   = 0;
    pA5      = {32{8'hA5}};
    rst_i    = 1'b0;
    enable_i = 1'b0;
    write_i  = 1'b0;
    addr_i   = '0;
    data_i   = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_ack", {255'd0, ack_o}, 256'd0);
    check("rst_data", data_o, 256'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // T1: preload line 3 by a write, then read it back with exact latency
    doReq("t1_pre", 1'b1, 32'h0000_0060, pA5, 0);
    check("t1_pre_data", data_o, 256'd0);
    finishReq("t1_pre");
    doReq("t1_rd", 1'b0, 32'h0000_0060, '0, 0);
    check("t1_rd_data", data_o, pA5);
    finishReq("t1_rd");
    check("t1_hold", data_o, pA5);

    // T2: write then read same line; write ack leaves data_o alone
    doReq("t2_wr", 1'b1, 32'h0000_0040, 256'h1234, 0);
    check("t2_wr_data", data_o, pA5);
    finishReq("t2_wr");
    doReq("t2_rd", 1'b0, 32'h0000_0040, '0, 0);
    check("t2_rd_data", data_o, 256'h1234);
    finishReq("t2_rd");

    // T3: enable held high -> re-accepted at edge 12, ack at edges 10 and 22
    @(negedge clk_i);
    enable_i = 1'b1;
    write_i  = 1'b0;
    addr_i   = 32'h0000_0060;
    pulses   = 0;
    @(posedge clk_i); #1;
    for (int k = 1; k <= 23; k++) begin
      @(posedge clk_i); #1;
      if (ack_o === 1'b1) pulses++;
      check("t3_ack", {255'd0, ack_o}, {255'd0, (k == 10 || k == 22)});
      if (k == 22) enable_i = 1'b0;
    end
    check("t3_pulses", 256'(pulses), 256'd2);
    check("t3_data", data_o, pA5);

    // T4: reset in the middle of a write to line 4 aborts it
    doReq("t4_pre", 1'b1, 32'h0000_0080, 256'h0BAD, 0);
    finishReq("t4_pre");
    @(negedge clk_i);
    enable_i = 1'b1;
    write_i  = 1'b1;
    addr_i   = 32'h0000_0080;
    data_i   = 256'hDEAD;
    @(posedge clk_i); #1;
    enable_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    check("t4_rst_ack", {255'd0, ack_o}, 256'd0);
    check("t4_rst_data", data_o, 256'd0);
    repeat (12) @(posedge clk_i);
    #1;
    check("t4_no_ack", {255'd0, ack_o}, 256'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    doReq("t4_rd", 1'b0, 32'h0000_0080, '0, 0);
    check("t4_rd_data", data_o, 256'h0BAD);
    finishReq("t4_rd");

    // T5: upper address bits alias onto line 1
    doReq("t5_wr", 1'b1, 32'h0000_4020, 256'hBEEF, 0);
    finishReq("t5_wr");
    doReq("t5_rd", 1'b0, 32'h0000_0020, '0, 0);
    check("t5_rd_data", data_o, 256'hBEEF);
    finishReq("t5_rd");

    // T6: inputs flipped at cycle 3 of a read must not matter
    doReq("t6_rd", 1'b0, 32'h0000_0060, '0, 3);
    check("t6_rd_data", data_o, pA5);
    finishReq("t6_rd");
    write_i = 1'b0;
    doReq("t6_chk", 1'b0, 32'h0000_0040, '0, 0);
    check("t6_line2_intact", data_o, 256'h1234);
    finishReq("t6_chk");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
